// File: rtl/range_counter_if.sv
// range_counter_if: configuration, control and status bundle for range_counter
interface range_counter_if #(
  parameter int WIDTH      = 7,
  parameter int STEP_WIDTH = 4
);
  logic [WIDTH-1:0]      start_value;
  logic [WIDTH-1:0]      end_value;
  logic [STEP_WIDTH-1:0] step;
  logic                  down;
  logic                  wrap_mode;
  logic                  load;
  logic                  count_en;
  logic [WIDTH-1:0]      current_value;
  logic                  busy;
  logic                  done;
  logic                  wrapped;
  logic                  range_err;
  modport master (
    output start_value, end_value, step, down, wrap_mode, load, count_en,
    input  current_value, busy, done, wrapped, range_err
  );
  modport slave (
    input  start_value, end_value, step, down, wrap_mode, load, count_en,
    output current_value, busy, done, wrapped, range_err
  );
endinterface

// File: rtl/range_counter.sv
// range_counter: loadable up/down range counter with clamped step, stop or wrap at end
module range_counter #(
  parameter int WIDTH      = 7,
  parameter int STEP_WIDTH = 4
) (
  input logic            clk,
  input logic            reset,
  range_counter_if.slave bus
);
  localparam int EW = (WIDTH > STEP_WIDTH ? WIDTH : STEP_WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                state_q, state_d;
  logic [WIDTH-1:0]      cur_q, cur_d;
  logic [WIDTH-1:0]      start_q, start_d;
  logic [WIDTH-1:0]      end_q, end_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  down_q, down_d;
  logic                  wrap_q, wrap_d;
  logic                  done_q, done_d;
  logic                  wrapped_q, wrapped_d;
  logic                  err_q, err_d;
  logic                  bad_load;
  logic                  hit;
  logic [WIDTH-1:0]      nxt;
  assign bad_load = bus.down ? (bus.start_value < bus.end_value) : (bus.start_value > bus.end_value);
  // Extended-width compare so a step past either rail clamps instead of wrapping
  assign hit = down_q ? (EW'(cur_q) <= EW'(end_q) + EW'(step_q))
                      : (EW'(cur_q) + EW'(step_q) >= EW'(end_q));
  assign nxt = hit ? end_q : (down_q ? cur_q - WIDTH'(step_q) : cur_q + WIDTH'(step_q));
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    start_d   = start_q;
    end_d     = end_q;
    step_d    = step_q;
    down_d    = down_q;
    wrap_d    = wrap_q;
    done_d    = 1'b0;
    wrapped_d = 1'b0;
    err_d     = 1'b0;
    if (bus.load) begin
      if (bad_load) begin
        err_d = 1'b1;
      end else begin
        start_d = bus.start_value;
        end_d   = bus.end_value;
        step_d  = bus.step == '0 ? STEP_WIDTH'(1) : bus.step;
        down_d  = bus.down;
        wrap_d  = bus.wrap_mode;
        cur_d   = bus.start_value;
        done_d  = bus.start_value == bus.end_value;
        state_d = (done_d && !bus.wrap_mode) ? DONE : RUN;
      end
    end else if (state_q == RUN && bus.count_en) begin
      if (cur_q == end_q) begin
        cur_d     = start_q;
        wrapped_d = 1'b1;
        done_d    = start_q == end_q;
        state_d   = wrap_q ? RUN : DONE;
      end else begin
        cur_d   = nxt;
        done_d  = hit;
        state_d = (hit && !wrap_q) ? DONE : RUN;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      start_q   <= '0;
      end_q     <= '0;
      step_q    <= '0;
      down_q    <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      start_q   <= start_d;
      end_q     <= end_d;
      step_q    <= step_d;
      down_q    <= down_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
      err_q     <= err_d;
    end
  end
  assign bus.current_value = cur_q;
  assign bus.busy          = state_q == RUN;
  assign bus.done          = done_q;
  assign bus.wrapped       = wrapped_q;
  assign bus.range_err     = err_q;
endmodule

// File: tb/tb_range_counter.sv
// tb_range_counter: directed + random stimulus, sequence-based reference model, queued scoreboard
module tb_range_counter;
  logic clk = 0;
  logic reset;
  int total = 0;
  int bad = 0;
  typedef struct {
    int v;
    bit b;
    bit d;
    bit w;
    bit e;
  } exp_t;
  exp_t expq[$];
  range_counter_if #(.WIDTH(7), .STEP_WIDTH(4)) bus();
  range_counter #(.WIDTH(7), .STEP_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  // Model: an accepted load expands the whole visiting sequence; running just walks an index
  int seq[$];
  int idx = 0;
  int mode = 0;
  bit wrapm = 0;
  int val = 0;
  always @(posedge clk) begin
    exp_t x;
    int s, e, st, v;
    x.d = 0; x.w = 0; x.e = 0;
    if (reset) begin
      mode = 0; val = 0; seq.delete();
    end else if (bus.load) begin
      s = int'(bus.start_value); e = int'(bus.end_value); st = int'(bus.step);
      if (st == 0) st = 1;
      if ((!bus.down && s > e) || (bus.down && s < e)) x.e = 1;
      else begin
        seq.delete(); v = s; seq.push_back(v);
        while (v != e) begin
          v = bus.down ? ((v - st < e) ? e : v - st) : ((v + st > e) ? e : v + st);
          seq.push_back(v);
        end
        idx = 0; wrapm = bus.wrap_mode; val = s;
        if (seq.size() == 1) begin x.d = 1; mode = wrapm ? 1 : 2; end
        else mode = 1;
      end
    end else if (mode == 1 && bus.count_en) begin
      if (idx == seq.size() - 1) begin
        idx = 0; x.w = 1; x.d = (seq.size() == 1);
      end else begin
        idx++;
        if (idx == seq.size() - 1) begin x.d = 1; if (!wrapm) mode = 2; end
      end
      val = seq[idx];
    end
    x.v = val; x.b = (mode == 1);
    expq.push_back(x);
  end
  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (expq.size() == 0) chk("queue_underflow", 0, 1);
    else begin
      x = expq.pop_front();
      chk("current_value", int'(bus.current_value), x.v);
      chk("busy", int'(bus.busy), int'(x.b));
      chk("done", int'(bus.done), int'(x.d));
      chk("wrapped", int'(bus.wrapped), int'(x.w));
      chk("range_err", int'(bus.range_err), int'(x.e));
    end
  end
  task automatic do_load(int s, int e, int st, bit dn, bit wr);
    bus.start_value = 7'(s); bus.end_value = 7'(e); bus.step = 4'(st);
    bus.down = dn; bus.wrap_mode = wr; bus.load = 1;
    @(negedge clk);
    bus.load = 0;
    bus.start_value = 7'($urandom); bus.end_value = 7'($urandom);
    bus.step = 4'($urandom); bus.down = 1'($urandom); bus.wrap_mode = 1'($urandom);
  endtask
  task automatic run(int n, bit en);
    bus.count_en = en;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    reset = 1;
    bus.load = 0; bus.count_en = 1; bus.start_value = 0; bus.end_value = 0;
    bus.step = 0; bus.down = 0; bus.wrap_mode = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    run(2, 1);
    do_load(0, 20, 1, 0, 0);    run(25, 1);
    do_load(3, 10, 4, 0, 0);    run(5, 1);
    do_load(20, 5, 5, 1, 1);    run(5, 1); run(3, 0); run(6, 1);
    do_load(120, 127, 15, 0, 0); run(3, 1);
    do_load(5, 0, 7, 1, 0);     run(3, 1);
    do_load(10, 2, 3, 0, 0);    run(2, 1);
    do_load(2, 8, 0, 0, 0);     run(8, 1);
    do_load(0, 30, 1, 0, 0);    run(12, 1);
    reset = 1; bus.start_value = 40; bus.end_value = 50; bus.load = 1;
    @(negedge clk);
    reset = 0; bus.load = 0;
    run(3, 1);
    do_load(0, 30, 2, 0, 1);    run(4, 1);
    do_load(50, 40, 3, 1, 0);   run(6, 1);
    do_load(9, 9, 3, 0, 1);     run(4, 1);
    do_load(9, 9, 3, 0, 0);     run(3, 1);
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      reset = (r < 2);
      bus.load = (r >= 2 && r < 10);
      bus.start_value = 7'($urandom); bus.end_value = 7'($urandom);
      bus.step = 4'($urandom);
      bus.down = ($urandom_range(0, 9) < 8) ? (bus.start_value > bus.end_value) : 1'($urandom);
      bus.wrap_mode = 1'($urandom);
      bus.count_en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    reset = 0; bus.load = 0;
    run(4, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/range_counter.md
RANGE_COUNTER -- requirements
Module: range_counter

Interface
REQ-001 Parameter WIDTH, default 7, counter and range width in bits.
REQ-002 Parameter STEP_WIDTH, default 4, step input width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-005 start_value  input  WIDTH  first value of range, sampled on load.
REQ-006 end_value  input  WIDTH  terminal value of range, sampled on load.
REQ-007 step  input  STEP_WIDTH  increment magnitude, sampled on load; 0 treated as 1.
REQ-008 down  input  1  direction, sampled on load: 0 = count up, 1 = count down.
REQ-009 wrap_mode  input  1  sampled on load: 0 = stop at end, 1 = reload start and continue.
REQ-010 load  input  1  single-cycle request: capture configuration and (re)start.
REQ-011 count_en  input  1  advance enable; low freezes count in RUN.
REQ-012 current_value  output  WIDTH  registered count.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse in the cycle current_value first equals end.
REQ-015 wrapped  output  1  one-cycle pulse in the cycle current_value reloads start in wrap mode.
REQ-016 range_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-017 FSM states IDLE, RUN, DONE; priority per edge: reset > load > count.
REQ-018 Load: start,end,step,down,wrap_mode captured into internal registers; inputs may change afterwards without effect.
REQ-019 Load rejected (range_err=1, state and current_value unchanged) when down=0 and start>end, or down=1 and start<end.
REQ-020 Accepted load with start!=end: next edge current_value=start, state RUN, busy=1.
REQ-021 Accepted load with start==end: next edge current_value=start, done=1; stop mode -> DONE, wrap mode -> RUN.
REQ-022 Load accepted from any state, including mid-RUN and DONE; restarts immediately, no done/wrapped from aborted run.
REQ-023 RUN, count_en=1, current!=end: up -> current+step clamped to end; down -> current-step clamped to end; comparison in WIDTH+1 bits so no overflow/underflow wrap.
REQ-024 Clamp reaching end: done=1 same cycle as new value; stop mode -> DONE, busy=0 that cycle.
REQ-025 RUN, wrap mode, count_en=1, current==end: current_value=start, wrapped=1; if start==end, done=1 also.
REQ-026 count_en=0 in RUN: value and state held, no pulses.
REQ-027 DONE: current_value holds end indefinitely; count_en ignored; only load or reset leaves.
REQ-028 IDLE: current_value held; count_en ignored.
REQ-029 done, wrapped, range_err never asserted more than one consecutive cycle except in wrap mode start==end with count_en held high.
REQ-030 Latency load->first value 1 cycle; each enabled edge advances exactly once.

Reset
REQ-031 reset=1 at edge: state IDLE, current_value=0, busy=0, done=0, wrapped=0, range_err=0, internal config registers 0.
REQ-032 Reset mid-RUN aborts without done/wrapped pulse; reset overrides a simultaneous load.

Verification
REQ-033 WIDTH=7: load start=0,end=20,step=1,up,stop, count_en=1 -> 0..20 over 21 cycles after load, done=1 only at 20, then DONE holding 20, busy=0.
REQ-034 start=3,end=10,step=4,up,stop -> 3,7,10 (clamped), done at 10.
REQ-035 start=20,end=5,step=5,down,wrap -> 20,15,10,5(done),20(wrapped),15,...; count_en low 3 cycles mid-run freezes value, no pulses.
REQ-036 start=120,end=127,step=15,up -> 120,127, no overflow to low values; down from 5 to 0 step 7 -> 5,0.
REQ-037 start=10,end=2,down=0 load -> range_err one cycle, state and current_value unchanged; step=0 load -> counts by 1.
REQ-038 reset asserted mid-RUN at value 12 -> next edge current_value=0, IDLE; load in same cycle as reset ignored; load mid-RUN restarts at new start next edge.
